// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM E-mode iteration datapath: digit codes,
// Q-format constants and the controller state encoding.
package bkm_pkg;

  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_NEG  = 2'b11;
  localparam logic [1:0] D_RSV  = 2'b10;

  // Q2.(W-2): two integer bits, the rest fraction.
  localparam int Q_INT_BITS = 2;

  function automatic int q_frac_bits(input int w);
    return w - Q_INT_BITS;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } bkm_state_e;

endpackage

// File: rtl/multiply_by_d.sv
// Complex product d*E for a digit d = d_x + j*d_y with components in {-1,0,+1};
// reserved component codes contribute zero. Results truncate to W bits.
module multiply_by_d
  import bkm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   d_x,
  input  logic [1:0]   d_y,
  output logic [W-1:0] re,
  output logic [W-1:0] im
);

  function automatic logic [W-1:0] term(input logic [1:0] code, input logic [W-1:0] v);
    case (code)
      D_POS:   return v;
      D_NEG:   return -v;
      default: return '0;
    endcase
  endfunction

  assign re = term(d_x, x) - term(d_y, y);
  assign im = term(d_x, y) + term(d_y, x);

endmodule

// File: rtl/bkm_e_iter.sv
// Digit-serial BKM E-mode iteration: E <= E + (d*E) >>> n for n = 1..N,
// one accepted digit per cycle, result held until the consumer takes it.
module bkm_e_iter
  import bkm_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 12,
  localparam int NW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x0,
  input  logic [W-1:0]  y0,
  input  logic          d_valid,
  input  logic [1:0]    d_x,
  input  logic [1:0]    d_y,
  output logic          d_ready,
  output logic [W-1:0]  x_res,
  output logic [W-1:0]  y_res,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic [NW-1:0] n_idx,
  output logic          d_err
);

  bkm_state_e state_q, state_d;

  logic [W-1:0]        e_x, e_y;
  logic [W-1:0]        prod_re, prod_im;
  logic signed [W-1:0] sh_re, sh_im;
  logic                accept, last, rsv;

  multiply_by_d #(.W(W)) u_mul (
    .x  (e_x),
    .y  (e_y),
    .d_x(d_x),
    .d_y(d_y),
    .re (prod_re),
    .im (prod_im)
  );

  assign sh_re  = $signed(prod_re) >>> n_idx;
  assign sh_im  = $signed(prod_im) >>> n_idx;
  assign accept = (state_q == ST_ITER) && d_valid;
  assign last   = (n_idx == NW'(N));
  assign rsv    = (d_x == D_RSV) || (d_y == D_RSV);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)          state_d = ST_ITER;
      ST_ITER: if (accept && last) state_d = ST_DONE;
      ST_DONE: if (res_ready)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      e_x     <= '0;
      e_y     <= '0;
      n_idx   <= '0;
      d_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (start) begin
          e_x   <= x0;
          e_y   <= y0;
          n_idx <= NW'(1);
          d_err <= 1'b0;
        end
        ST_ITER: if (accept) begin
          e_x <= e_x + sh_re;
          e_y <= e_y + sh_im;
          // Index parks at N in DONE so it never overflows NW bits.
          if (!last) n_idx <= n_idx + NW'(1);
          if (rsv)   d_err <= 1'b1;
        end
        ST_DONE: if (res_ready) n_idx <= '0;
        default: ;
      endcase
    end
  end

  assign d_ready   = (state_q == ST_ITER);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ITER) || (state_q == ST_DONE);
  assign x_res     = e_x;
  assign y_res     = e_y;

endmodule

// File: tb/tb_bkm_e_iter.sv
// Scoreboard bench for bkm_e_iter: an N=2 and an N=12 instance share stimulus;
// expected results are queued at stimulus time and popped when res_valid rises.
module tb_bkm_e_iter;

  logic        clk = 1'b0;
  logic        rst, start, d_valid, res_ready, sel;
  logic [15:0] x0, y0;
  logic [1:0]  d_x, d_y;

  logic        dr_s, rv_s, bz_s, de_s, dr_b, rv_b, bz_b, de_b;
  logic [15:0] xr_s, yr_s, xr_b, yr_b;
  logic [1:0]  ni_s;
  logic [3:0]  ni_b;

  logic        d_ready, res_valid, busy, d_err;
  logic [15:0] x_res, y_res;
  logic [3:0]  n_idx;

  logic [1:0]  dx_t[12], dy_t[12];
  logic [31:0] exp_q[$];
  logic        mid_en;
  logic [15:0] mid_x, mid_y;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bkm_e_iter #(.W(16), .N(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
    .d_valid(d_valid), .d_x(d_x), .d_y(d_y), .d_ready(dr_s),
    .x_res(xr_s), .y_res(yr_s), .res_valid(rv_s), .res_ready(res_ready),
    .busy(bz_s), .n_idx(ni_s), .d_err(de_s)
  );

  bkm_e_iter #(.W(16), .N(12)) dut_b (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
    .d_valid(d_valid), .d_x(d_x), .d_y(d_y), .d_ready(dr_b),
    .x_res(xr_b), .y_res(yr_b), .res_valid(rv_b), .res_ready(res_ready),
    .busy(bz_b), .n_idx(ni_b), .d_err(de_b)
  );

  assign d_ready   = sel ? dr_b : dr_s;
  assign res_valid = sel ? rv_b : rv_s;
  assign busy      = sel ? bz_b : bz_s;
  assign d_err     = sel ? de_b : de_s;
  assign x_res     = sel ? xr_b : xr_s;
  assign y_res     = sel ? yr_b : yr_s;
  assign n_idx     = sel ? ni_b : {2'b00, ni_s};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dval(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  // Reference iteration in plain integer arithmetic, wrapped to 16 bits.
  function automatic logic [31:0] model(input logic [15:0] xs, input logic [15:0] ys, input int nd);
    logic signed [15:0] x, y, re, im;
    int a, b;
    x = xs;
    y = ys;
    for (int n = 1; n <= nd; n++) begin
      a  = dval(dx_t[n-1]);
      b  = dval(dy_t[n-1]);
      re = 16'(a * int'(x) - b * int'(y));
      im = 16'(a * int'(y) + b * int'(x));
      x  = x + (re >>> n);
      y  = y + (im >>> n);
    end
    return {x, y};
  endfunction

  task automatic rand_digits();
    for (int i = 0; i < 12; i++) begin
      dx_t[i] = ($urandom_range(0, 1) == 0) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00);
      dy_t[i] = ($urandom_range(0, 1) == 0) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00);
    end
  endtask

  task automatic run_comp(input bit big, input bit toggle, input int hold,
                          input logic [15:0] xs, input logic [15:0] ys);
    int nd, k, cyc;
    logic [15:0] hx, hy;
    logic [31:0] ex;
    nd = big ? 12 : 2;
    sel = big; x0 = xs; y0 = ys; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start", 32'(busy), 32'd1);
    chk("n_idx_start", 32'(n_idx), 32'd1);
    chk("d_ready_iter", 32'(d_ready), 32'd1);
    k = 0; cyc = 0;
    while (k < nd && cyc < 100) begin
      d_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      d_x = dx_t[k]; d_y = dy_t[k];
      @(posedge clk); #1;
      if (d_valid) begin
        k++;
        if (mid_en && k == 1) begin
          chk("x_mid", 32'(x_res), 32'(mid_x));
          chk("y_mid", 32'(y_res), 32'(mid_y));
        end
      end else begin
        chk("n_idx_stall", 32'(n_idx), 32'(k + 1));
      end
      if (k < nd) chk("rv_early", 32'(res_valid), 32'd0);
      cyc++;
    end
    d_valid = 1'b0;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("sb_size", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk("x_res", 32'(x_res), 32'(ex[31:16]));
      chk("y_res", 32'(y_res), 32'(ex[15:0]));
    end
    hx = x_res; hy = y_res;
    for (int i = 0; i < hold; i++) begin
      start = (i % 2 == 0);
      @(posedge clk); #1;
      chk("rv_hold", 32'(res_valid), 32'd1);
      chk("x_hold", 32'(x_res), 32'(hx));
      chk("y_hold", 32'(y_res), 32'(hy));
    end
    start = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("rv_drop", 32'(res_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("n_idx_idle", 32'(n_idx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rx, ry;
    rst = 1'b1; start = 1'b0; d_valid = 1'b0; res_ready = 1'b0; sel = 1'b0;
    x0 = '0; y0 = '0; d_x = '0; d_y = '0; mid_en = 1'b0; mid_x = '0; mid_y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy_s", 32'(bz_s), 32'd0);
    chk("rst_rv_s", 32'(rv_s), 32'd0);
    chk("rst_dr_s", 32'(dr_s), 32'd0);
    chk("rst_x_s", 32'(xr_s), 32'd0);
    chk("rst_ni_b", 32'(ni_b), 32'd0);
    chk("rst_y_b", 32'(yr_b), 32'd0);

    // +1, +1 from 1.0
    dx_t[0] = 2'b01; dy_t[0] = 2'b00; dx_t[1] = 2'b01; dy_t[1] = 2'b00;
    exp_q.push_back({16'h7800, 16'h0000});
    mid_en = 1'b1; mid_x = 16'h6000; mid_y = 16'h0000;
    run_comp(1'b0, 1'b0, 0, 16'h4000, 16'h0000);

    // -1, -1 from 1.0
    dx_t[0] = 2'b11; dx_t[1] = 2'b11;
    exp_q.push_back({16'h1800, 16'h0000});
    mid_x = 16'h2000;
    run_comp(1'b0, 1'b0, 0, 16'h4000, 16'h0000);

    // +j then 0
    dx_t[0] = 2'b00; dy_t[0] = 2'b01; dx_t[1] = 2'b00; dy_t[1] = 2'b00;
    exp_q.push_back({16'h4000, 16'h2000});
    mid_x = 16'h4000; mid_y = 16'h2000;
    run_comp(1'b0, 1'b0, 0, 16'h4000, 16'h0000);
    mid_en = 1'b0;

    // Random digits, result held 5 cycles with start pulsing
    rand_digits();
    rx = 16'($urandom); ry = 16'($urandom);
    exp_q.push_back(model(rx, ry, 2));
    run_comp(1'b0, 1'b0, 5, rx, ry);

    // Reserved code acts as zero and flags d_err
    dx_t[0] = 2'b10; dy_t[0] = 2'b00; dx_t[1] = 2'b01; dy_t[1] = 2'b00;
    exp_q.push_back({16'h5000, 16'h0000});
    run_comp(1'b0, 1'b0, 0, 16'h4000, 16'h0000);
    chk("d_err_sticky", 32'(d_err), 32'd1);

    // Abort mid-iteration with reset; start in the same cycle must lose
    sel = 1'b0; x0 = 16'h4000; y0 = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("d_err_clear", 32'(d_err), 32'd0);
    d_valid = 1'b1; d_x = 2'b01; d_y = 2'b00;
    @(posedge clk); #1;
    d_valid = 1'b0;
    chk("x_before_rst", 32'(x_res), 32'h6000);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dr", 32'(d_ready), 32'd0);
    chk("abort_ni", 32'(n_idx), 32'd0);
    chk("abort_x", 32'(x_res), 32'd0);
    chk("abort_rv", 32'(res_valid), 32'd0);
    rand_digits();
    rx = 16'($urandom); ry = 16'($urandom);
    exp_q.push_back(model(rx, ry, 2));
    run_comp(1'b0, 1'b0, 0, rx, ry);

    // N=12: all-zero digits with d_valid toggling leaves E unchanged
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin dx_t[i] = 2'b00; dy_t[i] = 2'b00; end
    rx = 16'($urandom); ry = 16'($urandom);
    exp_q.push_back({rx, ry});
    run_comp(1'b1, 1'b1, 0, rx, ry);

    // N=12 random digits, full-rate
    rand_digits();
    rx = 16'($urandom_range(0, 16'h3fff)); ry = 16'($urandom_range(0, 16'h3fff));
    exp_q.push_back(model(rx, ry, 12));
    run_comp(1'b1, 1'b0, 0, rx, ry);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
